// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier with a generic operand width and per-operation
// signed/unsigned mode. Each multiplier bit takes one combined add+shift cycle.
// Signed operands are reduced to magnitudes on capture, and the product sign is
// re-applied in a single finish cycle. Result holds until the next completion.
module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 St,
    input  logic                 Sgn,
    input  logic [WIDTH-1:0]     Mplier,
    input  logic [WIDTH-1:0]     Mcand,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Result
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    // acc[2W:W] is the running partial product (one spare bit for the carry),
    // acc[W-1:0] starts as the multiplier magnitude and is shifted out LSB first.
    logic [PW:0]        acc;
    logic [WIDTH-1:0]   mcand_mag;
    logic               neg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     sum;

    // Magnitude of an operand; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? ((~v) + WIDTH'(1)) : v;
    endfunction

    // The high part is below 2^W before every add, so W+1 bits never overflow.
    assign sum  = acc[PW:WIDTH] + {1'b0, mcand_mag};

    assign Busy = (state != IDLE);

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode: St only counts in IDLE, so strobes while busy are dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (St) state_nxt = RUN;
            RUN:     if (cnt == LAST_CNT) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture on acceptance, then one add+shift per bit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc       <= '0;
            mcand_mag <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (St) begin
                        acc       <= {{(WIDTH + 1){1'b0}}, mag(Mplier, Sgn)};
                        mcand_mag <= mag(Mcand, Sgn);
                        neg       <= Sgn & (Mplier[WIDTH-1] ^ Mcand[WIDTH-1]);
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    if (acc[0]) acc <= {1'b0, sum, acc[WIDTH-1:1]};
                    else        acc <= acc >> 1;
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Output registers: Result is loaded only in FIN, and Done pulses alongside it.
    // Negating a zero magnitude gives zero again, so no negative-zero can appear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Done   <= 1'b0;
            Result <= '0;
        end else begin
            Done <= (state == FIN);
            if (state == FIN)
                Result <= neg ? ((~acc[PW-1:0]) + PW'(1)) : acc[PW-1:0];
        end
    end

endmodule
